// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared floating-point definitions for the FP datapath
//                blocks: bit positions of the operand special-class vector,
//                rounding-mode encodings, result classification and the
//                canonical quiet-NaN builder.
//  Contents    : c_SPC_*        bit positions inside the 4-bit special vector
//                round_mode_e   rounding-mode encodings
//                fp_class_e     priority-resolved result class
//                fp_classify()  special vector -> fp_class_e
//                fp_qnan()      canonical quiet NaN for a given format
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    // Bit positions inside the {nan, invalid, inf, zero} classification vector.
    localparam int unsigned c_SPC_NAN     = 3;
    localparam int unsigned c_SPC_INVALID = 2;
    localparam int unsigned c_SPC_INF     = 1;
    localparam int unsigned c_SPC_ZERO    = 0;

    // Widest packed format any block builds constants for.
    localparam int unsigned c_FP_MAX_W    = 64;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,   // nearest, ties to even
        RM_RTZ = 3'd1,   // toward zero
        RM_RDN = 3'd2,   // toward -infinity
        RM_RUP = 3'd3,   // toward +infinity
        RM_RMM = 3'd4    // nearest, ties away from zero
    } round_mode_e;

    // The square-root datapath only implements round-to-nearest-even.
    localparam round_mode_e c_SQRT_ROUND_MODE = RM_RNE;

    typedef enum logic [2:0] {
        CLS_NORMAL  = 3'd0,
        CLS_ZERO    = 3'd1,
        CLS_INF     = 3'd2,
        CLS_INVALID = 3'd3,
        CLS_NAN     = 3'd4
    } fp_class_e;

    // Resolve the (possibly multi-hot) special vector with the fixed
    // priority nan > invalid > inf > zero > normal.
    function automatic fp_class_e fp_classify(input logic [3:0] special);
        fp_class_e cls;
        if (special[c_SPC_NAN])
            cls = CLS_NAN;
        else if (special[c_SPC_INVALID])
            cls = CLS_INVALID;
        else if (special[c_SPC_INF])
            cls = CLS_INF;
        else if (special[c_SPC_ZERO])
            cls = CLS_ZERO;
        else
            cls = CLS_NORMAL;
        return cls;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros} for a format with
    // sw fraction bits and ew exponent bits, right-aligned in c_FP_MAX_W bits.
    function automatic logic [c_FP_MAX_W-1:0] fp_qnan(input int sw, input int ew);
        logic [c_FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(c_FP_MAX_W); i++) begin
            if ((i >= sw - 1) && (i < sw + ew))
                v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_round_pack_hca.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_round_pack_hca
//  Description : Han-Carlson parallel-prefix adder. Odd bit positions run a
//                Kogge-Stone tree (after one Brent-Kung style pre-combine);
//                even positions pick up their carry in one final pass.
//                The carry-in is folded into the bit-0 generate term.
//  Ports       : a_i    [WIDTH-1:0]  addend
//                b_i    [WIDTH-1:0]  addend
//                cin_i               carry in
//                sum_o  [WIDTH-1:0]  a_i + b_i + cin_i (low WIDTH bits)
//                cout_o              carry out of bit WIDTH-1
//  Revision    : 1.0  initial release
// ============================================================================
module sqrt_round_pack_hca #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Kogge-Stone levels over the odd positions; after the pre-combine each
    // odd node spans 2 bits and doubles per level, so clog2 levels suffice.
    localparam int c_NKS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Returns {cout, carry into bit WIDTH-1 ... carry into bit 0}.
    function automatic logic [WIDTH:0] f_carries(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        logic [WIDTH:0]   c;
        int               d;

        g    = a & b;
        p    = a ^ b;
        g[0] = g[0] | (p[0] & cin);

        // Pre-combine: odd node i absorbs its even neighbour i-1.
        g_n = g;
        p_n = p;
        for (int i = 1; i < WIDTH; i += 2) begin
            g_n[i] = g[i] | (p[i] & g[i-1]);
            p_n[i] = p[i] & p[i-1];
        end
        g = g_n;
        p = p_n;

        // Kogge-Stone on odd nodes with span 2, 4, 8, ...
        for (int k = 1; k <= c_NKS; k++) begin
            d   = 1 << k;
            g_n = g;
            p_n = p;
            for (int i = 1; i < WIDTH; i += 2) begin
                if (i >= d) begin
                    g_n[i] = g[i] | (p[i] & g[i-d]);
                    p_n[i] = p[i] & p[i-d];
                end
            end
            g = g_n;
            p = p_n;
        end

        // Even nodes: one combine with the completed odd prefix below them.
        g_n = g;
        for (int i = 2; i < WIDTH; i += 2) begin
            g_n[i] = g[i] | (p[i] & g[i-1]);
        end
        g = g_n;

        c = {g, cin};
        return c;
    endfunction

    logic [WIDTH:0] w_carry;

    assign w_carry = f_carries(a_i, b_i, cin_i);
    assign sum_o   = a_i ^ b_i ^ w_carry[WIDTH-1:0];
    assign cout_o  = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/sqrt_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_round_pack
//  Description : Final two pipeline stages of the square-root unit.
//                Stage R decides round-to-nearest-even and increments the
//                fraction; stage P resolves special operands and packs the
//                IEEE-style result. Valid/ready on both sides, latency two
//                cycles, one result per cycle sustained.
//  Parameters  : sig_width  stored fraction width (23 / 11 / 8 ...)
//                exp_width  biased exponent width
//  Ports       : clk          clock, rising edge
//                reset        asynchronous active-high reset
//                in_valid     upstream result available
//                in_ready     block accepts in_* this cycle
//                in_sig_nr    {hidden, fraction, guard, sticky}
//                in_exp       biased, already halved/rebiased exponent
//                in_sign      sign, only applied to a zero result
//                in_special   {nan, invalid, inf, zero}
//                out_valid    z / flags valid
//                out_ready    downstream accepts
//                z            packed {sign, exp, frac}
//                out_inexact  rounding discarded non-zero bits
//                out_invalid  operand was negative non-zero
//  Revision    : 1.0  initial release
// ============================================================================
module sqrt_round_pack
    import fp_pkg::*;
#(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sig_width+2:0]           in_sig_nr,
    input  logic [exp_width-1:0]           in_exp,
    input  logic                           in_sign,
    input  logic [3:0]                     in_special,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [exp_width+sig_width:0]   z,
    output logic                           out_inexact,
    output logic                           out_invalid
);

    localparam int                     c_Z_W       = exp_width + sig_width + 1;
    localparam logic [c_FP_MAX_W-1:0]  c_QNAN_FULL = fp_qnan(sig_width, exp_width);
    localparam logic [c_Z_W-1:0]       c_QNAN      = c_QNAN_FULL[c_Z_W-1:0];
    localparam logic [c_Z_W-1:0]       c_PINF      = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}};

    // Stage R payload: everything stage P needs to choose and pack a result.
    typedef struct packed {
        logic                 sign;
        logic [exp_width-1:0] exp;
        logic [sig_width-1:0] frac;
        logic                 ovf;
        logic                 inexact;
        logic [3:0]           special;
    } r_stage_t;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_valid_q;
    logic p_valid_q;
    logic w_p_accept;
    logic w_r_accept;

    assign w_p_accept = !p_valid_q || out_ready;
    assign w_r_accept = !r_valid_q || w_p_accept;
    assign in_ready   = w_r_accept;

    // ------------------------------------------------------------------
    // Stage R: round decision and increment
    // ------------------------------------------------------------------
    logic [sig_width-1:0] w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_round_up;
    logic [sig_width:0]   w_sum;
    logic                 w_unused_cout;
    logic                 w_carry;
    logic [exp_width-1:0] w_exp_inc;
    r_stage_t             r_data_d;
    r_stage_t             r_data_q;

    assign w_frac   = in_sig_nr[sig_width+1:2];
    assign w_guard  = in_sig_nr[1];
    assign w_sticky = in_sig_nr[0];

    // Nearest-even: round up above the halfway point, or exactly at it
    // when the retained LSB is odd.
    assign w_round_up = (c_SQRT_ROUND_MODE == RM_RNE) && w_guard && (w_sticky || w_frac[0]);

    // Zero-extended by one bit so the top sum bit is the fraction carry;
    // the adder's own carry-out can never be set.
    sqrt_round_pack_hca #(
        .WIDTH (sig_width + 1)
    ) u_inc (
        .a_i    ({1'b0, w_frac}),
        .b_i    ({(sig_width + 1){1'b0}}),
        .cin_i  (w_round_up),
        .sum_o  (w_sum),
        .cout_o (w_unused_cout)
    );

    assign w_carry   = w_sum[sig_width];
    assign w_exp_inc = in_exp + {{(exp_width - 1){1'b0}}, w_carry};

    always_comb begin
        r_data_d         = '0;
        r_data_d.sign    = in_sign;
        r_data_d.exp     = w_exp_inc;
        // A fraction carry means 1.111..1 rounded up to 10.000..0.
        r_data_d.frac    = w_carry ? {sig_width{1'b0}} : w_sum[sig_width-1:0];
        r_data_d.ovf     = &w_exp_inc;
        r_data_d.inexact = w_guard || w_sticky;
        r_data_d.special = in_special;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else if (w_r_accept) begin
            r_valid_q <= in_valid;
            if (in_valid)
                r_data_q <= r_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage P: special select and pack
    // ------------------------------------------------------------------
    logic [c_Z_W-1:0] z_d;
    logic             inexact_d;
    logic             invalid_d;
    logic [c_Z_W-1:0] z_q;
    logic             inexact_q;
    logic             invalid_q;

    // The sign of a non-zero square root is always positive, so only a
    // zero result carries in_sign through.
    always_comb begin
        z_d       = '0;
        inexact_d = 1'b0;
        invalid_d = 1'b0;
        case (fp_classify(r_data_q.special))
            CLS_NAN: begin
                z_d = c_QNAN;
            end
            CLS_INVALID: begin
                z_d       = c_QNAN;
                invalid_d = 1'b1;
            end
            CLS_INF: begin
                z_d = c_PINF;
            end
            CLS_ZERO: begin
                z_d = {r_data_q.sign, {(c_Z_W - 1){1'b0}}};
            end
            default: begin
                if (r_data_q.ovf) begin
                    z_d       = c_PINF;
                    inexact_d = 1'b1;
                end else begin
                    z_d       = {1'b0, r_data_q.exp, r_data_q.frac};
                    inexact_d = r_data_q.inexact;
                end
            end
        endcase
    end

    // Output registers only load alongside a valid transfer, so z and the
    // flags stay frozen while the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            z_q       <= '0;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
        end else if (w_p_accept) begin
            p_valid_q <= r_valid_q;
            if (r_valid_q) begin
                z_q       <= z_d;
                inexact_q <= inexact_d;
                invalid_q <= invalid_d;
            end
        end
    end

    assign out_valid   = p_valid_q;
    assign z           = z_q;
    assign out_inexact = inexact_q;
    assign out_invalid = invalid_q;

    // The significand stage always delivers a normalised value for
    // non-special operands.
    a_hidden_bit : assert property (
        @(posedge clk) disable iff (reset)
        (in_valid && in_ready && (in_special == 4'b0000)) |-> in_sig_nr[sig_width+2]
    );

endmodule
`default_nettype wire

// File: tb/tb_sqrt_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sqrt_round_pack
//  Description : Directed self-checking bench for sqrt_round_pack (single
//                precision). Each scenario task drives its own vectors and
//                compares against hand-computed results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sqrt_round_pack;

    localparam int SW = 23;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW+2:0] in_sig_nr;
    logic [EW-1:0] in_exp;
    logic          in_sign;
    logic [3:0]    in_special;
    logic          out_valid;
    logic          out_ready;
    logic [EW+SW:0] z;
    logic          out_inexact;
    logic          out_invalid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sqrt_round_pack #(
        .sig_width (SW),
        .exp_width (EW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sig_nr   (in_sig_nr),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .in_special  (in_special),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z           (z),
        .out_inexact (out_inexact),
        .out_invalid (out_invalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [25:0] sig, input logic [7:0] ex,
                          input logic sg, input logic [3:0] spc);
        in_sig_nr  = sig;
        in_exp     = ex;
        in_sign    = sg;
        in_special = spc;
    endtask

    // One isolated transaction into an empty pipeline; latency counts clock
    // edges from the accepting edge to the first cycle out_valid is seen.
    task automatic run_one(input logic [25:0] sig, input logic [7:0] ex,
                           input logic sg, input logic [3:0] spc,
                           output logic [31:0] zo, output logic inx,
                           output logic inv, output int lat, output logic seen);
        set_in(sig, ex, sg, spc);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        seen = out_valid;
        zo   = z;
        inx  = out_inexact;
        inv  = out_invalid;
        tick();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        set_in('0, '0, 1'b0, 4'b0000);
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (z !== 32'h0) begin n_err++; $display("FAIL reset z: got %h want 00000000", z); end
        n_vec++; if (out_inexact !== 1'b0) begin n_err++; $display("FAIL reset inexact: got %b want 0", out_inexact); end
        n_vec++; if (out_invalid !== 1'b0) begin n_err++; $display("FAIL reset invalid: got %b want 0", out_invalid); end
        reset = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_round();
        logic [25:0] t_sig [0:7];
        logic [7:0]  t_exp [0:7];
        logic [31:0] t_z   [0:7];
        logic        t_inx [0:7];
        logic [31:0] zo;
        logic        inx;
        logic        inv;
        int          lat;
        logic        seen;
        // exact; round up (g,~s,odd); tie to even stays; carry into exponent;
        // carry to overflow; g&s rounds up; tie with odd lsb rounds up;
        // sticky alone truncates
        t_sig = '{26'h2000000, 26'h2000006, 26'h2000002, 26'h3FFFFFF,
                  26'h3FFFFFF, 26'h2000007, 26'h200000E, 26'h2000001};
        t_exp = '{8'h80, 8'h7F, 8'h7F, 8'h7F, 8'hFE, 8'h7F, 8'h7F, 8'h7F};
        t_z   = '{32'h40000000, 32'h3F800002, 32'h3F800000, 32'h40000000,
                  32'h7F800000, 32'h3F800002, 32'h3F800004, 32'h3F800000};
        t_inx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_one(t_sig[i], t_exp[i], 1'b0, 4'b0000, zo, inx, inv, lat, seen);
            n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL round[%0d] out_valid: got %b want 1", i, seen); end
            n_vec++; if (zo !== t_z[i]) begin n_err++; $display("FAIL round[%0d] z: got %h want %h", i, zo, t_z[i]); end
            n_vec++; if (inx !== t_inx[i]) begin n_err++; $display("FAIL round[%0d] inexact: got %b want %b", i, inx, t_inx[i]); end
            n_vec++; if (inv !== 1'b0) begin n_err++; $display("FAIL round[%0d] invalid: got %b want 0", i, inv); end
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL round[%0d] latency: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [3:0]  t_spc [0:7];
        logic        t_sgn [0:7];
        logic [31:0] t_z   [0:7];
        logic        t_inv [0:7];
        logic [31:0] zo;
        logic        inx;
        logic        inv;
        int          lat;
        logic        seen;
        t_spc = '{4'b0100, 4'b0001, 4'b0001, 4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b0110};
        t_sgn = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        t_z   = '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7FC00000,
                  32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
        t_inv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        // Significand with guard/sticky set and a would-overflow exponent:
        // specials must ignore it entirely.
        for (int i = 0; i < 8; i++) begin
            run_one(26'h3FFFFFF, 8'hFE, t_sgn[i], t_spc[i], zo, inx, inv, lat, seen);
            n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL special[%0d] out_valid: got %b want 1", i, seen); end
            n_vec++; if (zo !== t_z[i]) begin n_err++; $display("FAIL special[%0d] z: got %h want %h", i, zo, t_z[i]); end
            n_vec++; if (inx !== 1'b0) begin n_err++; $display("FAIL special[%0d] inexact: got %b want 0", i, inx); end
            n_vec++; if (inv !== t_inv[i]) begin n_err++; $display("FAIL special[%0d] invalid: got %b want %b", i, inv, t_inv[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] v_sig [0:2];
        logic [7:0]  v_exp [0:2];
        logic [3:0]  v_spc [0:2];
        logic [31:0] v_z   [0:2];
        logic [31:0] got [$];
        int          idx;
        int          acc;
        v_sig = '{26'h2000000, 26'h2000006, 26'h2000000};
        v_exp = '{8'h80, 8'h7F, 8'h00};
        v_spc = '{4'b0000, 4'b0000, 4'b0001};
        v_z   = '{32'h40000000, 32'h3F800002, 32'h80000000};
        idx = 0;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) set_in(v_sig[idx], v_exp[idx], 1'b1, v_spc[idx]);
            #1;
            if (c >= 2) begin
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall[%0d] out_valid: got %b want 1", c, out_valid); end
                n_vec++; if (z !== v_z[0]) begin n_err++; $display("FAIL stall[%0d] z held: got %h want %h", c, z, v_z[0]); end
            end
            if (in_valid && in_ready) begin
                idx++;
                acc++;
            end
            tick();
        end
        #1;
        n_vec++; if (acc != 2) begin n_err++; $display("FAIL stall accepted: got %0d want 2", acc); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) set_in(v_sig[idx], v_exp[idx], 1'b1, v_spc[idx]);
            #1;
            if (out_valid) got.push_back(z);
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (got.size() != 3) begin n_err++; $display("FAIL drain count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_vec++; if (got[i] !== v_z[i]) begin n_err++; $display("FAIL drain[%0d] z: got %h want %h", i, got[i], v_z[i]); end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [25:0] v_sig [0:3];
        logic [7:0]  v_exp [0:3];
        logic [31:0] v_z   [0:3];
        logic [31:0] got [$];
        int          first_c;
        int          last_c;
        int          stalls;
        v_sig = '{26'h2000006, 26'h200000E, 26'h3FFFFFF, 26'h2000000};
        v_exp = '{8'h7F, 8'h7F, 8'h80, 8'h01};
        v_z   = '{32'h3F800002, 32'h3F800004, 32'h40800000, 32'h00800000};
        out_ready = 1'b1;
        stalls  = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 4);
            if (c < 4) set_in(v_sig[c], v_exp[c], 1'b0, 4'b0000);
            #1;
            if (in_valid && !in_ready) stalls++;
            if (out_valid) begin
                got.push_back(z);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (stalls != 0) begin n_err++; $display("FAIL b2b in_ready stalls: got %0d want 0", stalls); end
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL b2b count: got %0d want 4", got.size()); end
        n_vec++; if (last_c - first_c != 3) begin n_err++; $display("FAIL b2b spacing: got %0d want 3", last_c - first_c); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                n_vec++; if (got[i] !== v_z[i]) begin n_err++; $display("FAIL b2b[%0d] z: got %h want %h", i, got[i], v_z[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] zo;
        logic        inx;
        logic        inv;
        int          lat;
        logic        seen;
        int          stale;
        out_ready = 1'b0;
        set_in(26'h3FFFFFF, 8'h7F, 1'b0, 4'b0000);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midreset pre out_valid: got %b want 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
        n_vec++; if (z !== 32'h0) begin n_err++; $display("FAIL midreset z: got %h want 00000000", z); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset in_ready: got %b want 1", in_ready); end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL midreset stale outputs: got %0d want 0", stale); end
        run_one(26'h2000006, 8'h7F, 1'b0, 4'b0000, zo, inx, inv, lat, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL postreset out_valid: got %b want 1", seen); end
        n_vec++; if (zo !== 32'h3F800002) begin n_err++; $display("FAIL postreset z: got %h want 3f800002", zo); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL postreset latency: got %0d want 2", lat); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
